// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: loader state encoding, instruction memory depth
// and the byte-lane order used by both the loader and the memory read side.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_WORD = 2'd1,
        S_WRITE     = 2'd2,
        S_DONE      = 2'd3
    } ld_state_t;

    localparam int IM_DEPTH = 256;

    // Big-endian: byte 0 of a word (lowest address) carries bits [31:24].
    localparam logic LANE_MSB_FIRST = 1'b1;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] b);
        logic [1:0] lane;
        lane = LANE_MSB_FIRST ? 2'd3 - b : b;
        return w[8*lane +: 8];
    endfunction

endpackage

// File: rtl/im_loader.sv
// Streams a 32-bit program image into the byte-wide instruction memory,
// four byte writes per word, and holds the CPU in reset until it is complete.
module im_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH = IM_DEPTH,
    parameter int AW    = 8,
    parameter int CW    = 7
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [CW-1:0] i_nwords,
    input  logic [31:0]   i_word,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_we,
    output logic [AW-1:0] o_waddr,
    output logic [7:0]    o_wdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_cpu_hold
);

    localparam int NW_MAX = DEPTH / 4;

    ld_state_t     state;
    logic [AW-1:0] base;
    logic [CW-1:0] rem;
    logic [1:0]    bcnt;
    logic [31:0]   word;

    // All outputs are registered: each branch sets them for the state it enters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            base       <= '0;
            rem        <= '0;
            bcnt       <= '0;
            word       <= '0;
            o_ready    <= 1'b0;
            o_we       <= 1'b0;
            o_waddr    <= '0;
            o_wdata    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_cpu_hold <= 1'b1;
        end else begin
            o_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        rem        <= i_nwords;
                        base       <= '0;
                        o_done     <= 1'b0;
                        o_err      <= 1'b0;
                        o_cpu_hold <= 1'b1;
                        if (i_nwords == '0) begin
                            state      <= S_DONE;
                            o_done     <= 1'b1;
                            o_cpu_hold <= 1'b0;
                        end else if (i_nwords > CW'(NW_MAX)) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
                        end else begin
                            state   <= S_WAIT_WORD;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b1;
                        end
                    end
                end
                S_WAIT_WORD: begin
                    if (i_valid) begin
                        word    <= i_word;
                        bcnt    <= 2'd0;
                        state   <= S_WRITE;
                        o_ready <= 1'b0;
                        o_we    <= 1'b1;
                        o_waddr <= base;
                        o_wdata <= lane_byte(i_word, 2'd0);
                    end
                end
                S_WRITE: begin
                    if (bcnt != 2'd3) begin
                        bcnt    <= bcnt + 2'd1;
                        o_we    <= 1'b1;
                        o_waddr <= base + AW'(bcnt) + AW'(1);
                        o_wdata <= lane_byte(word, bcnt + 2'd1);
                    end else begin
                        base <= base + AW'(4);
                        rem  <= rem - CW'(1);
                        if (rem == CW'(1)) begin
                            state      <= S_DONE;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
                            o_cpu_hold <= 1'b0;
                        end else begin
                            state   <= S_WAIT_WORD;
                            o_ready <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
